a_matrix_col_consumer: RTL and testbench



---
 rtl/gcn_pkg.sv | 29 ++
 rtl/gcn_mac_lane.sv | 65 ++++++
 rtl/a_matrix_col_consumer.sv | 124 ++++++++++++
 tb/tb_a_matrix_col_consumer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared constants, FSM state encoding and element-slice helpers for the
// A-matrix column consumer and its multiply-accumulate lanes.
package gcn_pkg;

    localparam int N_NODE  = 25;
    localparam int ELEM_W  = 16;
    localparam int FRAC_W  = 8;
    localparam int ACC_W   = 40;
    localparam int REQ_GAP = 3;

    localparam int PROD_W  = 2 * ELEM_W;
    localparam int VEC_W   = N_NODE * ELEM_W;
    localparam int COL_W   = $clog2(N_NODE);
    localparam int GAP_W   = $clog2(REQ_GAP + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Bit offset of element i inside a packed N_NODE x ELEM_W vector.
    function automatic int elem_lo(input int i);
        return i * ELEM_W;
    endfunction

endpackage

// File: rtl/gcn_mac_lane.sv
// One output row of y = A * x: a signed accumulator with clear/multiply-add,
// then shift by FRAC_W and narrow (saturating when A_MATRIX_SAT_EN is defined).
module gcn_mac_lane
    import gcn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              load,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] x,
    output logic [ELEM_W-1:0] y
);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod;
    logic        [ELEM_W-1:0] y_q, y_d;
    logic        [ELEM_W-1:0] narrow;

    assign prod = $signed(a) * $signed(x);

`ifdef A_MATRIX_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32768);
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_q >>> FRAC_W;
        if (shifted > Y_MAX) begin
            narrow = Y_MAX[ELEM_W-1:0];
        end else if (shifted < Y_MIN) begin
            narrow = Y_MIN[ELEM_W-1:0];
        end else begin
            narrow = shifted[ELEM_W-1:0];
        end
    end
`else
    // Arithmetic shift followed by truncation is just a bit slice.
    assign narrow = acc_q[FRAC_W +: ELEM_W];
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        y_d = load ? narrow : y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/a_matrix_col_consumer.sv
// Requests N_NODE columns of A from the BRAM supplier and accumulates y = A * x
// for one feature channel. Output saturation is selected by A_MATRIX_SAT_EN.
module a_matrix_col_consumer
    import gcn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VEC_W-1:0] x_vec,
    output logic             need_data,
    input  logic             data_v,
    input  logic [VEC_W-1:0] in_fea,
    output logic             busy,
    output logic             out_v,
    output logic [VEC_W-1:0] y_vec,
    output logic [2:0]       state_dbg
);

    // Column handshake: need_data is a one-cycle request (high exactly while in
    // REQ); the supplier answers with one data_v pulse carrying the column.
    // Only a data_v seen in WAIT is consumed; in any other state it is dropped.

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              need_q, need_d;
    logic              busy_q, busy_d;
    logic              out_v_q, out_v_d;
    logic [VEC_W-1:0]  x_q, x_d;
    logic [ELEM_W-1:0] x_col;
    logic              run_start, mac_en, y_load;

    assign x_col     = x_q[col_q * ELEM_W +: ELEM_W];
    assign run_start = (state_q == IDLE) && start;
    assign mac_en    = (state_q == WAIT) && data_v;
    assign y_load    = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        gap_d   = gap_q;
        x_d     = x_q;
        need_d  = 1'b0;
        out_v_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_vec;
                    col_d   = '0;
                    gap_d   = '0;
                    need_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (data_v) begin
                    if (col_q == COL_W'(N_NODE - 1)) begin
                        state_d = DONE;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(REQ_GAP - 1)) begin
                    need_d  = 1'b1;
                    state_d = REQ;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DONE: begin
                out_v_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            gap_q   <= '0;
            x_q     <= '0;
            need_q  <= 1'b0;
            busy_q  <= 1'b0;
            out_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            gap_q   <= gap_d;
            x_q     <= x_d;
            need_q  <= need_d;
            busy_q  <= busy_d;
            out_v_q <= out_v_d;
        end
    end

    for (genvar i = 0; i < N_NODE; i++) begin : g_lane
        gcn_mac_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (run_start),
            .en   (mac_en),
            .load (y_load),
            .a    (in_fea[elem_lo(i) +: ELEM_W]),
            .x    (x_col),
            .y    (y_vec[elem_lo(i) +: ELEM_W])
        );
    end

    assign need_data = need_q;
    assign busy      = busy_q;
    assign out_v     = out_v_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_a_matrix_col_consumer.sv
// Directed bench for a_matrix_col_consumer with a wrapping-address supplier
// model and a queue of expected result vectors.
module tb_a_matrix_col_consumer;
  import gcn_pkg::*;

  logic             clk;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] x_vec;
  logic             need_data;
  logic             data_v;
  logic [VEC_W-1:0] in_fea;
  logic             busy;
  logic             out_v;
  logic [VEC_W-1:0] y_vec;
  logic [2:0]       state_dbg;

  a_matrix_col_consumer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_vec     (x_vec),
    .need_data (need_data),
    .data_v    (data_v),
    .in_fea    (in_fea),
    .busy      (busy),
    .out_v     (out_v),
    .y_vec     (y_vec),
    .state_dbg (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [VEC_W-1:0] exp_q[$];

  logic [ELEM_W-1:0] a_mat [N_NODE][N_NODE];  // [row][col]
  logic [ELEM_W-1:0] x_arr [N_NODE];

  int need_cnt    = 0;
  int dv_cnt      = 0;
  int out_cnt     = 0;
  int resp_delay  = 1;
  int stall_col   = -1;
  bit spurious_en = 1'b0;

  task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] model_y();
    logic [VEC_W-1:0] r;
    longint acc;
    r = '0;
    for (int i = 0; i < N_NODE; i++) begin
      acc = 0;
      for (int j = 0; j < N_NODE; j++)
        acc += longint'($signed(a_mat[i][j])) * longint'($signed(x_arr[j]));
      acc = acc >>> FRAC_W;
`ifdef A_MATRIX_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`endif
      r[i*ELEM_W +: ELEM_W] = acc[ELEM_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] splat(input logic [ELEM_W-1:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_NODE; i++) r[i*ELEM_W +: ELEM_W] = v;
    return r;
  endfunction

  // supplier: answers need_data after resp_delay+1 cycles, column address wraps
  int sup_addr = 0;
  int sup_cnt  = 0;
  bit sup_pend = 1'b0;
  bit sup_spur = 1'b0;
  always @(posedge clk) begin
    #2;
    data_v = 1'b0;
    in_fea = '0;
    if (rst) begin
      sup_addr = 0;
      sup_pend = 1'b0;
      sup_spur = 1'b0;
    end else begin
      if (sup_spur) begin
        data_v   = 1'b1;
        in_fea   = {VEC_W{1'b1}};
        sup_spur = 1'b0;
      end else if (sup_pend) begin
        if (sup_cnt == 0) begin
          data_v = 1'b1;
          for (int i = 0; i < N_NODE; i++) in_fea[i*ELEM_W +: ELEM_W] = a_mat[i][sup_addr];
          sup_addr = (sup_addr + 1) % N_NODE;
          sup_pend = 1'b0;
          sup_spur = spurious_en;
          dv_cnt++;
        end else begin
          sup_cnt--;
        end
      end
      if (need_data) begin
        need_cnt++;
        sup_pend = 1'b1;
        sup_cnt  = (sup_addr == stall_col) ? resp_delay + 20 : resp_delay;
      end
    end
  end

  // scoreboard: every out_v consumes one expected vector
  always @(negedge clk) begin
    if (!rst && out_v) begin
      out_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_out_v observed=1 expected=0");
      end
      if (exp_q.size() > 0) check("y_vec", y_vec, exp_q.pop_front());
    end
  end

  task automatic load_x();
    for (int j = 0; j < N_NODE; j++) x_vec[j*ELEM_W +: ELEM_W] = x_arr[j];
  endtask

  task automatic pulse_start();
    load_x();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int k = 0; k < 2000; k++) begin
      if (out_cnt >= target) break;
      @(posedge clk); #1;
    end
    checks++;
    assert (out_cnt >= target) else begin
      failures++;
      $error("FAIL out_v_timeout observed=%0d expected=%0d", out_cnt, target);
    end
  endtask

  task automatic randomize_ax();
    for (int i = 0; i < N_NODE; i++) begin
      x_arr[i] = ELEM_W'($urandom_range(0, 65535));
      for (int j = 0; j < N_NODE; j++) a_mat[i][j] = ELEM_W'($urandom_range(0, 65535));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x_vec = '0;
    for (int i = 0; i < N_NODE; i++) begin
      x_arr[i] = '0;
      for (int j = 0; j < N_NODE; j++) a_mat[i][j] = '0;
    end
    y_vec_dummy();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_need_data", VEC_W'(need_data), '0);
    check("rst_busy", VEC_W'(busy), '0);
    check("rst_out_v", VEC_W'(out_v), '0);
    check("rst_y_vec", y_vec, '0);
    check("rst_state", VEC_W'(state_dbg), VEC_W'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // identity A, x_j = j
    for (int i = 0; i < N_NODE; i++) begin
      x_arr[i] = ELEM_W'(i * 256);
      for (int j = 0; j < N_NODE; j++) a_mat[i][j] = (i == j) ? 16'h0100 : 16'h0000;
    end
    begin
      logic [VEC_W-1:0] e;
      for (int i = 0; i < N_NODE; i++) e[i*ELEM_W +: ELEM_W] = ELEM_W'(i * 256);
      exp_q.push_back(e);
    end
    need_cnt = 0;
    pulse_start();
    wait_out(1);
    check("ident_need_cnt", VEC_W'(need_cnt), VEC_W'(25));
    check("ident_busy_after", VEC_W'(busy), '0);
    repeat (10) @(posedge clk); #1;
    check("ident_out_cnt", VEC_W'(out_cnt), VEC_W'(1));
    check("ident_need_idle", VEC_W'(need_cnt), VEC_W'(25));

    // all-ones A
    for (int i = 0; i < N_NODE; i++) begin
      x_arr[i] = 16'h0100;
      for (int j = 0; j < N_NODE; j++) a_mat[i][j] = 16'h0100;
    end
    exp_q.push_back(splat(16'h1900));
    pulse_start();
    wait_out(2);

    // overflow
    for (int i = 0; i < N_NODE; i++) begin
      x_arr[i] = 16'h7FFF;
      for (int j = 0; j < N_NODE; j++) a_mat[i][j] = 16'h7FFF;
    end
`ifdef A_MATRIX_SAT_EN
    exp_q.push_back(splat(16'h7FFF));
`else
    exp_q.push_back(splat(16'hE700));
`endif
    pulse_start();
    wait_out(3);

    // back-to-back with ignored starts during run 1
    randomize_ax();
    need_cnt = 0;
    exp_q.push_back(model_y());
    pulse_start();
    repeat (40) @(posedge clk); #1;
    check("b2b_busy_mid", VEC_W'(busy), VEC_W'(1));
    pulse_start();
    repeat (30) @(posedge clk); #1;
    pulse_start();
    wait_out(4);
    for (int j = 0; j < N_NODE; j++) x_arr[j] = ELEM_W'($urandom_range(0, 65535));
    exp_q.push_back(model_y());
    pulse_start();
    wait_out(5);
    check("b2b_need_cnt", VEC_W'(need_cnt), VEC_W'(50));

    // reset mid-run after the 10th data_v
    randomize_ax();
    dv_cnt = 0;
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      if (dv_cnt >= 10) break;
      @(posedge clk); #1;
    end
    check("mid_dv_reached", VEC_W'(dv_cnt >= 10), VEC_W'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_need_data", VEC_W'(need_data), '0);
    check("mid_rst_busy", VEC_W'(busy), '0);
    check("mid_rst_out_v", VEC_W'(out_v), '0);
    check("mid_rst_y_vec", y_vec, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model_y());
    pulse_start();
    wait_out(6);

    // supplier stall plus spurious data_v in GAP
    randomize_ax();
    stall_col   = 7;
    spurious_en = 1'b1;
    exp_q.push_back(model_y());
    pulse_start();
    wait_out(7);
    stall_col   = -1;
    spurious_en = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("final_queue_empty", VEC_W'(exp_q.size()), '0);
    check("final_out_cnt", VEC_W'(out_cnt), VEC_W'(7));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic y_vec_dummy();
    data_v = 1'b0;
    in_fea = '0;
  endtask

endmodule
